// File: rtl/ram_op_sequencer_pkg.sv
// Shared types and constants for the RAM operation sequencer.
package ram_op_sequencer_pkg;

    localparam int unsigned W_DATA = 24;
    localparam int unsigned W_ADDR = 9;

    localparam logic [W_ADDR-1:0] ADDR_U = 9'd155;
    localparam logic [W_ADDR-1:0] ADDR_V = 9'd10;
    localparam logic [W_ADDR-1:0] ADDR_W = 9'd95;
    localparam logic [W_ADDR-1:0] ADDR_K = 9'd180;
    localparam logic [W_ADDR-1:0] ADDR_X = 9'd115;

    localparam logic [W_DATA-1:0] K_VAL = 24'd7;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_U,
        S_WR_V,
        S_WR_W,
        S_WR_K,
        S_RD_U,
        S_RD_V,
        S_RD_W,
        S_RD_K,
        S_RD_END,
        S_MUL_A,
        S_MUL_B,
        S_MUL_C,
        S_WR_X,
        S_DONE
    } state_e;

endpackage

// File: rtl/ram_op_sequencer_mult.sv
// seq_mult24: shift-add multiplier, one multiplier bit per cycle (LSB first),
// low W bits of the product kept. Bit 0 is handled on the go edge so the
// product is ready (rdy pulse) exactly W cycles after go.
module seq_mult24
    import ram_op_sequencer_pkg::*;
#(
    parameter int unsigned W = W_DATA
) (
    input  logic         clk,
    input  logic         RE_n,
    input  logic         go,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] p,
    output logic         rdy
);

    localparam int unsigned CW = $clog2(W) + 1;

    logic [W-1:0]  acc_q;
    logic [W-1:0]  mcand_q;
    logic [W-1:0]  mplier_q;
    logic [CW-1:0] cnt_q;
    logic          run_q;
    logic          rdy_q;

    // Iteration control: bit counter, running flag and completion pulse.
    always_ff @(posedge clk or negedge RE_n) begin
        if (!RE_n) begin
            cnt_q <= '0;
            run_q <= 1'b0;
            rdy_q <= 1'b0;
        end else if (go) begin
            cnt_q <= CW'(1);
            run_q <= 1'b1;
            rdy_q <= 1'b0;
        end else if (run_q) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
                run_q <= 1'b0;
                rdy_q <= 1'b1;
            end else begin
                rdy_q <= 1'b0;
            end
        end else begin
            rdy_q <= 1'b0;
        end
    end

    // Datapath: conditionally accumulate the shifted multiplicand.
    always_ff @(posedge clk) begin
        if (go) begin
            acc_q    <= b[0] ? a : '0;
            mcand_q  <= a << 1;
            mplier_q <= b >> 1;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

    assign p   = acc_q;
    assign rdy = rdy_q;

endmodule

// File: rtl/ram_op_sequencer.sv
// ram_op_sequencer: stores U, V, W and a constant through a single RAM port,
// reads them back, computes X = V or X = 2*U*V*W*K (mod 2^W_DATA), writes X
// to RAM and pulses done. All outputs are registered from the next state.
module ram_op_sequencer
    import ram_op_sequencer_pkg::*;
#(
    parameter int unsigned          W_DATA = ram_op_sequencer_pkg::W_DATA,
    parameter int unsigned          W_ADDR = ram_op_sequencer_pkg::W_ADDR,
    parameter logic [W_ADDR-1:0]    ADDR_U = ram_op_sequencer_pkg::ADDR_U,
    parameter logic [W_ADDR-1:0]    ADDR_V = ram_op_sequencer_pkg::ADDR_V,
    parameter logic [W_ADDR-1:0]    ADDR_W = ram_op_sequencer_pkg::ADDR_W,
    parameter logic [W_ADDR-1:0]    ADDR_K = ram_op_sequencer_pkg::ADDR_K,
    parameter logic [W_ADDR-1:0]    ADDR_X = ram_op_sequencer_pkg::ADDR_X,
    parameter logic [W_DATA-1:0]    K_VAL  = ram_op_sequencer_pkg::K_VAL
) (
    input  logic              clk,
    input  logic              RE_n,
    input  logic              start,
    input  logic [W_DATA-1:0] U,
    input  logic [W_DATA-1:0] V,
    input  logic [W_DATA-1:0] W,
    input  logic              operation,
    input  logic [W_DATA-1:0] ram_o,
    output logic [W_DATA-1:0] ram_d,
    output logic [W_ADDR-1:0] ram_addr,
    output logic              ram_r,
    output logic              ram_w,
    output logic              ram_e,
    output logic [W_DATA-1:0] X,
    output logic              done,
    output logic              busy
);

    state_e state_q, state_d;

    logic [W_DATA-1:0] u_q, v_q, w_q;
    logic              op_q;
    logic [W_DATA-1:0] ur_q, vr_q, wr_q, kr_q;
    logic [W_DATA-1:0] res_q, res_d;

    logic              en_q, en_d, rstb_q, rstb_d, wstb_q, wstb_d;
    logic [W_ADDR-1:0] addr_q, addr_d;
    logic [W_DATA-1:0] wdata_q, wdata_d;
    logic [W_DATA-1:0] x_q;
    logic              done_q, busy_q;

    logic              mul_go, mul_rdy;
    logic [W_DATA-1:0] mul_a, mul_b, mul_p;

    seq_mult24 #(.W(W_DATA)) u_mult (
        .clk  (clk),
        .RE_n (RE_n),
        .go   (mul_go),
        .a    (mul_a),
        .b    (mul_b),
        .p    (mul_p),
        .rdy  (mul_rdy)
    );

    // Next state, multiplier launches, and the RAM bus for the coming cycle.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        mul_go  = 1'b0;
        mul_a   = mul_p;
        mul_b   = kr_q;
        en_d    = 1'b0;
        rstb_d  = 1'b0;
        wstb_d  = 1'b0;
        addr_d  = '0;
        wdata_d = '0;

        case (state_q)
            S_IDLE:   if (start) state_d = S_WR_U;
            S_WR_U:   state_d = S_WR_V;
            S_WR_V:   state_d = S_WR_W;
            S_WR_W:   state_d = S_WR_K;
            S_WR_K:   state_d = S_RD_U;
            S_RD_U:   state_d = S_RD_V;
            S_RD_V:   state_d = S_RD_W;
            S_RD_W:   state_d = S_RD_K;
            S_RD_K:   state_d = S_RD_END;
            S_RD_END: begin
                if (op_q) begin
                    state_d = S_MUL_A;
                    mul_go  = 1'b1;
                    mul_a   = ur_q;
                    mul_b   = wr_q;
                end else begin
                    state_d = S_WR_X;
                    res_d   = vr_q;
                end
            end
            S_MUL_A: begin
                if (mul_rdy) begin
                    state_d = S_MUL_B;
                    mul_go  = 1'b1;
                    mul_b   = kr_q;
                end
            end
            S_MUL_B: begin
                if (mul_rdy) begin
                    state_d = S_MUL_C;
                    mul_go  = 1'b1;
                    mul_b   = vr_q;
                end
            end
            S_MUL_C: begin
                if (mul_rdy) begin
                    state_d = S_WR_X;
                    res_d   = mul_p << 1;
                end
            end
            S_WR_X:   state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // WR_U is only entered from IDLE, where the operand registers are
        // loaded on the same edge, so its data comes straight from the port.
        case (state_d)
            S_WR_U: begin en_d = 1'b1; wstb_d = 1'b1; addr_d = ADDR_U; wdata_d = U;     end
            S_WR_V: begin en_d = 1'b1; wstb_d = 1'b1; addr_d = ADDR_V; wdata_d = v_q;   end
            S_WR_W: begin en_d = 1'b1; wstb_d = 1'b1; addr_d = ADDR_W; wdata_d = w_q;   end
            S_WR_K: begin en_d = 1'b1; wstb_d = 1'b1; addr_d = ADDR_K; wdata_d = K_VAL; end
            S_RD_U: begin en_d = 1'b1; rstb_d = 1'b1; addr_d = ADDR_U; end
            S_RD_V: begin en_d = 1'b1; rstb_d = 1'b1; addr_d = ADDR_V; end
            S_RD_W: begin en_d = 1'b1; rstb_d = 1'b1; addr_d = ADDR_W; end
            S_RD_K: begin en_d = 1'b1; rstb_d = 1'b1; addr_d = ADDR_K; end
            S_WR_X: begin en_d = 1'b1; wstb_d = 1'b1; addr_d = ADDR_X; wdata_d = res_d; end
            default: ;
        endcase
    end

    // Control state and registered outputs; reset idles the RAM bus at once.
    always_ff @(posedge clk or negedge RE_n) begin
        if (!RE_n) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            rstb_q  <= 1'b0;
            wstb_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            x_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            rstb_q  <= rstb_d;
            wstb_q  <= wstb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= (state_d == S_DONE);
            busy_q  <= (state_d != S_IDLE);
            if (state_d == S_DONE) begin
                x_q <= res_q;
            end
        end
    end

    // Operand capture on accept, and read-back one cycle after each address.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && start) begin
            u_q  <= U;
            v_q  <= V;
            w_q  <= W;
            op_q <= operation;
        end
        if (state_q == S_RD_V)   ur_q <= ram_o;
        if (state_q == S_RD_W)   vr_q <= ram_o;
        if (state_q == S_RD_K)   wr_q <= ram_o;
        if (state_q == S_RD_END) kr_q <= ram_o;
        res_q <= res_d;
    end

    assign ram_e    = en_q;
    assign ram_r    = rstb_q;
    assign ram_w    = wstb_q;
    assign ram_addr = addr_q;
    assign ram_d    = wdata_q;
    assign X        = x_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule

// File: doc/ram_op_sequencer.md
# ram_op_sequencer

Sequential controller that sits directly upstream of the 512x24 RAM datapath. It accepts operands U, V, W and an operation select, writes them and the constant 7 into fixed RAM locations over a single RAM port, then reads them back and computes the result. The result is written to RAM address 115 and presented on X with a one-cycle `done` pulse. Only one RAM access occurs per cycle, so the RAM sees one write or one read at a time instead of several parallel instances.

## Interface
Parameters:
- W_DATA, 24, data word width
- W_ADDR, 9, RAM address width
- ADDR_U, 9'd155, U location
- ADDR_V, 9'd10, V location
- ADDR_W, 9'd95, W location
- ADDR_K, 9'd180, constant location
- ADDR_X, 9'd115, result location
- K_VAL, 24'd7, constant written to ADDR_K

Ports:
- clk, input, 1, single clock; all state changes on the rising edge.
- RE_n, input, 1, reset, asynchronous and active-low.
- start, input, 1, request; sampled only in IDLE.
- U, V, W, input, 24 each, operands; captured on the edge that accepts `start`.
- operation, input, 1, 0 gives X = V; 1 gives X = 2·V·U·W·7 mod 2^24.
- ram_o, input, 24, RAM read data.
- ram_d, output, 24, RAM write data.
- ram_addr, output, 9, RAM address.
- ram_r, output, 1, RAM read strobe.
- ram_w, output, 1, RAM write strobe.
- ram_e, output, 1, RAM enable.
- X, output, 24, result; held until the next accepted start.
- done, output, 1, one-cycle pulse when X is valid.
- busy, output, 1, high in every state except IDLE.

## Operation
FSM states, with one cycle per state unless stated:
- IDLE: `start`=1 captures U, V, W and operation, then goes to WR_U.
- WR_U, WR_V, WR_W, WR_K: drive ram_e=1, ram_w=1, ram_r=0, with the address and data for U, V, W, then K_VAL.
- RD_U, RD_V, RD_W, RD_K: drive ram_e=1, ram_r=1, ram_w=0, with the address of U, V, W, then K.
- RD_END: bus idle.
- Read data is captured one cycle after its address is issued:
  - Ur is captured in RD_V, Vr in RD_W, Wr in RD_K, Kr in RD_END.
- After RD_END: operation=0 goes to WR_X with res=Vr; operation=1 goes to MUL_A.
- MUL_A (24 cycles): p = Ur·Wr.
- MUL_B (24 cycles): p = p·Kr.
- MUL_C (24 cycles): p = p·Vr.
  - On exit from MUL_C: res = p<<1.
- WR_X: write res to ADDR_X, then go to DONE.
- DONE: X=res, done=1, then go to IDLE.
- Arithmetic: every product keeps only its low 24 bits; the final shift drops bit 23. Unsigned throughout.
- `start` is ignored while busy; no queueing.
- RAM bus idle value: ram_e=ram_r=ram_w=0 and ram_addr=ram_d=0. This holds in IDLE, RD_END, MUL_* and DONE.
- RE_n low, at any time including mid-operation:
  - State returns to IDLE.
  - X=0, done=0, busy=0.
  - RAM bus goes to its idle value immediately (asynchronous).
  - RAM contents are not cleared by this block.

## Timing
- Counting from the edge that accepts `start`:
  - operation=0: WR_* in cycles 1–4, RD_* and RD_END in cycles 5–9, WR_X in cycle 10, done high in cycle 11.
  - operation=1: MUL_* in cycles 10–81, WR_X in cycle 82, done high in cycle 83.
- `start` held high through DONE is accepted in the first IDLE cycle after DONE. Back-to-back transactions therefore cost 12 or 84 cycles each.
- All outputs are registered. done and X update on the same edge.
- RAM writes commit on the rising edge at the end of each WR_* cycle.

## Structure
- Shared package holds:
  - the state enum;
  - the W_DATA and W_ADDR widths;
  - the address constants ADDR_U, ADDR_V, ADDR_W, ADDR_K, ADDR_X;
  - K_VAL.
- One sub-module, seq_mult24: a 24-cycle shift-add multiplier producing the low 24 bits.
  - Ports: clk, RE_n, go, a, b, p, rdy.
  - It examines one multiplier bit per cycle, LSB first.
  - It is instantiated once and reused for MUL_A, MUL_B and MUL_C.

## Test plan
- Reset: RE_n low mid-MUL_B → same cycle: X=0, done=0, busy=0 and RAM strobes low; after release, state is IDLE.
- operation=0, U=3, V=5, W=4:
  - Write order: 155←3, 10←5, 95←4, 180←7, then 115←5.
  - X=5 with done in cycle 11.
- operation=1, U=3, V=5, W=4 → X=840 (0x000348), done in cycle 83, and RAM[115]=840.
- Overflow: operation=1, U=V=W=0xFFFFFF → X=0xFFFFF2.
- Busy: start pulsed in cycle 3 of a transaction → ignored; exactly one done pulse.
- Back-to-back: start held high for two operation=0 requests → second done arrives 12 cycles after the first, and X updates to the second V.
